// File: rtl/truth_table_checker.sv
// Response checker for a 3-input combinational block: waits for each stimulus vector to settle,
// compares Q against TRUTH_TABLE, and accumulates error count, first failure and coverage.
// Optional per-vector sticky failure map: define TTC_FAIL_MAP_EN.
module truth_table_checker #(
    parameter logic [7:0] TRUTH_TABLE   = 8'hE8,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             Q,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_q,
    output logic [7:0]       coverage,
`ifdef TTC_FAIL_MAP_EN
    output logic [7:0]       fail_map,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STABLE = 2'd2
    } state_t;

    localparam logic [7:0]       CNT_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] vec_s;
    logic [2:0] vec_q_r;
    logic [2:0] vec_q_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       cmp_s;
    logic       match_s;
    logic [7:0] cov_nxt_s;

    assign vec_s = {A, B, C};

    // Settle sequencing: a vector change always restarts the window, even on the compare edge.
    always_comb begin
        state_nxt_s = state_r;
        vec_q_nxt_s = vec_q_r;
        cnt_nxt_s   = cnt_r;
        cmp_s       = 1'b0;
        if (clr) begin
            state_nxt_s = IDLE;
            vec_q_nxt_s = 3'd0;
            cnt_nxt_s   = 8'd0;
        end else if (!en) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = SETTLE;
                    vec_q_nxt_s = vec_s;
                    cnt_nxt_s   = CNT_LOAD;
                end
                STABLE: begin
                    if (vec_s != vec_q_r) begin
                        state_nxt_s = SETTLE;
                        vec_q_nxt_s = vec_s;
                        cnt_nxt_s   = CNT_LOAD;
                    end else begin
                        state_nxt_s = STABLE;
                    end
                end
                SETTLE: begin
                    if (vec_s != vec_q_r) begin
                        vec_q_nxt_s = vec_s;
                        cnt_nxt_s   = CNT_LOAD;
                    end else if (cnt_r != 8'd0) begin
                        cnt_nxt_s = cnt_r - 8'd1;
                    end else begin
                        cmp_s       = 1'b1;
                        state_nxt_s = STABLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    assign match_s   = (Q == TRUTH_TABLE[vec_q_r]);
    assign cov_nxt_s = coverage | (8'd1 << vec_q_r);

    // Sequencer state, latched vector and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            vec_q_r <= 3'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            vec_q_r <= vec_q_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Result registers; only the compare edge changes anything other than chk_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid      <= 1'b0;
            chk_pass       <= 1'b0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_fail_vec <= 3'd0;
            first_fail_q   <= 1'b0;
            coverage       <= 8'd0;
            done           <= 1'b0;
        end else if (clr) begin
            chk_valid      <= 1'b0;
            chk_pass       <= 1'b0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_fail_vec <= 3'd0;
            first_fail_q   <= 1'b0;
            coverage       <= 8'd0;
            done           <= 1'b0;
        end else begin
            chk_valid <= cmp_s;
            if (cmp_s) begin
                chk_pass <= match_s;
                coverage <= cov_nxt_s;
                done     <= (cov_nxt_s == 8'hFF);
                if (!match_s) begin
                    if (err_cnt != ERR_MAX) begin
                        err_cnt <= err_cnt + ERR_ONE;
                    end
                    if (!err_flag) begin
                        err_flag       <= 1'b1;
                        first_fail_vec <= vec_q_r;
                        first_fail_q   <= Q;
                    end
                end
            end
        end
    end

`ifdef TTC_FAIL_MAP_EN
    // Sticky per-vector failure map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_map <= 8'd0;
        end else if (clr) begin
            fail_map <= 8'd0;
        end else if (cmp_s && !match_s) begin
            fail_map <= fail_map | (8'd1 << vec_q_r);
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a run-length model of the stimulus predicts every
// output each cycle; literal expectations pin the main scenarios. A CNT_W=2 copy checks saturation.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n, en, clr, A, B, C, Q;
    logic       chk_valid, chk_pass, err_flag, first_fail_q, done;
    logic [7:0] err_cnt;
    logic [2:0] first_fail_vec;
    logic [7:0] coverage;
    logic       chk_valid2, chk_pass2, err_flag2, first_fail_q2, done2;
    logic [1:0] err_cnt2;
    logic [2:0] first_fail_vec2;
    logic [7:0] coverage2;
`ifdef TTC_FAIL_MAP_EN
    logic [7:0] fail_map, fail_map2;
`endif

    always #5 clk = ~clk;

    truth_table_checker #(.TRUTH_TABLE(8'hE8), .SETTLE_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .A(A), .B(B), .C(C), .Q(Q),
        .chk_valid(chk_valid), .chk_pass(chk_pass), .err_cnt(err_cnt), .err_flag(err_flag),
        .first_fail_vec(first_fail_vec), .first_fail_q(first_fail_q), .coverage(coverage),
`ifdef TTC_FAIL_MAP_EN
        .fail_map(fail_map),
`endif
        .done(done));

    truth_table_checker #(.TRUTH_TABLE(8'hE8), .SETTLE_CYCLES(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .A(A), .B(B), .C(C), .Q(Q),
        .chk_valid(chk_valid2), .chk_pass(chk_pass2), .err_cnt(err_cnt2), .err_flag(err_flag2),
        .first_fail_vec(first_fail_vec2), .first_fail_q(first_fail_q2), .coverage(coverage2),
`ifdef TTC_FAIL_MAP_EN
        .fail_map(fail_map2),
`endif
        .done(done2));

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic majority(input logic [2:0] v);
        return (int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2;
    endfunction

    // Model: a vector is checked when it has been seen on SETTLE+1 consecutive enabled edges.
    localparam int SETTLE = 4;
    logic [2:0] run_vec;
    int         run_len;
    logic       m_valid, m_pass, m_flag, m_ffq, m_done;
    int         m_cnt8, m_cnt2;
    logic [2:0] m_ffv;
    logic [7:0] m_cov, m_map;

    task automatic model_clear();
        run_len = 0; m_valid = 0; m_pass = 0; m_flag = 0; m_ffq = 0; m_done = 0;
        m_cnt8 = 0; m_cnt2 = 0; m_ffv = 0; m_cov = 0; m_map = 0; run_vec = 0;
    endtask

    always begin
        @(posedge clk);
        if (!rst_n || clr) begin
            model_clear();
        end else begin
            m_valid = 0;
            if (!en) begin
                run_len = 0;
            end else begin
                if (run_len == 0 || {A, B, C} != run_vec) begin
                    run_vec = {A, B, C};
                    run_len = 1;
                end else begin
                    run_len++;
                end
                if (run_len == SETTLE + 1) begin
                    m_valid = 1;
                    m_pass  = (Q == majority(run_vec));
                    m_cov[run_vec] = 1'b1;
                    if (!m_pass) begin
                        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                        m_map[run_vec] = 1'b1;
                        if (!m_flag) begin
                            m_flag = 1; m_ffv = run_vec; m_ffq = Q;
                        end
                    end
                    m_done = (m_cov == 8'hFF);
                end
            end
        end
        #1;
        if (rst_n) begin
            if (chk_valid) pulses++;
            chk("chk_valid", 32'(chk_valid), 32'(m_valid));
            chk("chk_pass", 32'(chk_pass), 32'(m_pass));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt8));
            chk("err_cnt_w2", 32'(err_cnt2), 32'(m_cnt2));
            chk("err_flag", 32'(err_flag), 32'(m_flag));
            chk("first_fail_vec", 32'(first_fail_vec), 32'(m_ffv));
            chk("first_fail_q", 32'(first_fail_q), 32'(m_ffq));
            chk("coverage", 32'(coverage), 32'(m_cov));
            chk("done", 32'(done), 32'(m_done));
`ifdef TTC_FAIL_MAP_EN
            chk("fail_map", 32'(fail_map), 32'(m_map));
`endif
        end
    end

    // Drive {A,B,C}=v and Q=q for n rising edges, starting from a falling edge.
    task automatic hold(input logic [2:0] v, input logic q, input int n);
        {A, B, C} = v;
        Q = q;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(chk_valid), 32'd0);
        chk({tag, "_pass"}, 32'(chk_pass), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_err_flag"}, 32'(err_flag), 32'd0);
        chk({tag, "_ffv"}, 32'(first_fail_vec), 32'd0);
        chk({tag, "_ffq"}, 32'(first_fail_q), 32'd0);
        chk({tag, "_coverage"}, 32'(coverage), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    int p0;

    initial begin
        model_clear();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; {A, B, C} = 3'd0; Q = 1'b0;
        repeat (2) @(negedge clk);
        expect_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector held: exactly one check at E0+4
        en = 1'b1;
        hold(3'd0, 1'b0, 10);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_pass", 32'(chk_pass), 32'd1);
        chk("t1_cov", 32'(coverage), 32'h01);
        chk("t1_err", 32'(err_cnt), 32'd0);

        // Two failures; first-failure capture sticks
        hold(3'd3, 1'b0, 6);
        chk("t2_err1", 32'(err_cnt), 32'd1);
        hold(3'd5, 1'b0, 6);
        chk("t2_err2", 32'(err_cnt), 32'd2);
        chk("t2_flag", 32'(err_flag), 32'd1);
        chk("t2_ffv", 32'(first_fail_vec), 32'd3);
        chk("t2_ffq", 32'(first_fail_q), 32'd0);

        // Aborted vector is never checked
        p0 = pulses;
        hold(3'd1, 1'b0, 2);
        hold(3'd2, 1'b0, 6);
        chk("t3_pulses", 32'(pulses - p0), 32'd1);
        chk("t3_cov1", 32'(coverage[1]), 32'd0);
        chk("t3_cov2", 32'(coverage[2]), 32'd1);

        // Q glitching during settle is ignored; only the compare edge samples it
        hold(3'd7, 1'b0, 3);
        hold(3'd7, 1'b1, 3);
        chk("glitch_pass", 32'(chk_pass), 32'd1);

        // en dropped mid-settle abandons the vector
        p0 = pulses;
        hold(3'd6, 1'b1, 2);
        en = 1'b0;
        hold(3'd6, 1'b1, 4);
        chk("en_abort", 32'(pulses - p0), 32'd0);
        en = 1'b1;

        // clr then full correct sweep
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        expect_all_zero("clr");
        p0 = pulses;
        for (int v = 0; v < 8; v++) hold(3'(v), majority(3'(v)), 6);
        chk("t4_pulses", 32'(pulses - p0), 32'd8);
        chk("t4_err", 32'(err_cnt), 32'd0);
        chk("t4_cov", 32'(coverage), 32'hFF);
        chk("t4_done", 32'(done), 32'd1);

        // Five mismatches: CNT_W=2 copy saturates at 3
        for (int v = 0; v < 5; v++) hold(3'(v), ~majority(3'(v)), 6);
        chk("t5_err8", 32'(err_cnt), 32'd5);
        chk("t5_err2", 32'(err_cnt2), 32'd3);
        chk("t5_flag2", 32'(err_flag2), 32'd1);
        chk("t5_ffv", 32'(first_fail_vec), 32'd0);
        chk("t5_ffq", 32'(first_fail_q), 32'd1);

        // Asynchronous reset mid-settle after a failure
        hold(3'd3, 1'b0, 2);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        expect_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        hold(3'd3, 1'b0, 6);
        chk("rst_no_pulse", 32'(pulses - p0), 32'd0);

        // Synchronous clr mid-settle after a failure
        en = 1'b1;
        hold(3'd4, 1'b1, 6);
        chk("pre_clr_flag", 32'(err_flag), 32'd1);
        hold(3'd3, 1'b0, 2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        en = 1'b0;
        expect_all_zero("clr_mid");
        p0 = pulses;
        hold(3'd3, 1'b0, 6);
        chk("clr_no_pulse", 32'(pulses - p0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
